// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: haz_cause_e stall-reason encoding, default parameter constants,
// and a small saturating-increment helper used by the stall counter.
package hazard_pkg;

    localparam int NUM_REGS_DEF        = 32;
    localparam int MAX_OUTSTANDING_DEF = 4;
    localparam int CNT_W_DEF           = 32;

    // Encoded in priority order: a lower value wins when several causes apply.
    typedef enum logic [2:0] {
        HAZ_NONE     = 3'd0,
        HAZ_LOAD_USE = 3'd1,
        HAZ_SB_RAW   = 3'd2,
        HAZ_SB_WAW   = 3'd3,
        HAZ_SB_FULL  = 3'd4
    } haz_cause_e;

    // Returns 1 when the increment should be suppressed (counter already all-ones).
    function automatic logic cnt_saturated(input logic [63:0] cnt, input int width);
        logic sat;
        sat = 1'b1;
        for (int i = 0; i < width; i++) begin
            sat = sat & cnt[i];
        end
        return sat;
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of ID/EX/WB hazard inputs and pipeline-control outputs.
// Latency: n/a (wiring only).
// Backpressure: n/a; stalls are expressed through pc_write / if_id_write / ctrl_sel.
//
// Modports:
//   master - pipeline side: drives decode/execute/writeback status, receives controls
//   slave  - hazard controller: consumes status, drives controls, busy and stall_cnt
interface hazard_control_unit_if #(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
);
    import hazard_pkg::*;

    localparam int REG_AW = $clog2(NUM_REGS);

    // ID stage
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_long_op;
    // ID_EX register contents
    logic              id_ex_mem_read;
    logic [REG_AW-1:0] id_ex_rd;
    // Variable-latency writeback
    logic              wb_done;
    logic [REG_AW-1:0] wb_rd;
    // Control flow
    logic              ex_redirect;

    // Pipeline controls
    logic              pc_write;
    logic              if_id_write;
    logic              if_id_flush;
    logic              ctrl_sel;
    haz_cause_e        stall_cause;
    logic [NUM_REGS-1:0] busy;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_long_op,
        output id_ex_mem_read, id_ex_rd, wb_done, wb_rd, ex_redirect,
        input  pc_write, if_id_write, if_id_flush, ctrl_sel, stall_cause, busy, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_long_op,
        input  id_ex_mem_read, id_ex_rd, wb_done, wb_rd, ex_redirect,
        output pc_write, if_id_write, if_id_flush, ctrl_sel, stall_cause, busy, stall_cnt
    );

endinterface

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for variable-latency writers, with occupancy count.
// Latency: queries are combinational; set/clear become visible one cycle after the edge.
// Backpressure: none internally; the caller must not set when full or when rd is busy.
//
// Ports: clk, rst_n; set_vld/set_rd mark a register busy; clr_vld/clr_rd retire it;
// q_rs1/q_rs2 (+used) return rsN_hit, q_rd returns rd_busy; full reports occupancy
// after this cycle's clear reaching MAX_OUTSTANDING; busy is the registered vector.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int REG_AW          = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_vld,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                clr_vld,
    input  logic [REG_AW-1:0]   clr_rd,
    input  logic [REG_AW-1:0]   q_rs1,
    input  logic                q_rs1_used,
    input  logic [REG_AW-1:0]   q_rs2,
    input  logic                q_rs2_used,
    input  logic [REG_AW-1:0]   q_rd,
    output logic                rs1_hit,
    output logic                rs2_hit,
    output logic                rd_busy,
    output logic                full,
    output logic [NUM_REGS-1:0] busy
);

    localparam int OCC_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [OCC_W-1:0]    occ_after_clr;
    logic                clr_eff;
    logic                set_eff;

    // Combinational queries. A retirement in the current cycle already counts
    // as free: the register file is write-first, so a reader sees the new value.
    always_comb begin
        clr_eff       = clr_vld && (clr_rd != '0) && busy_q[clr_rd];
        set_eff       = set_vld && (set_rd != '0);
        occ_after_clr = occ_q - OCC_W'(clr_eff);

        rs1_hit = q_rs1_used && (q_rs1 != '0) && busy_q[q_rs1]
                  && !(clr_vld && (clr_rd == q_rs1));
        rs2_hit = q_rs2_used && (q_rs2 != '0) && busy_q[q_rs2]
                  && !(clr_vld && (clr_rd == q_rs2));
        rd_busy = (q_rd != '0) && busy_q[q_rd]
                  && !(clr_vld && (clr_rd == q_rd));
        full    = (occ_after_clr == OCC_W'(MAX_OUTSTANDING));
    end

    // Next state. A clear on a register that is not busy changes nothing,
    // so the occupancy count cannot underflow on a stray writeback.
    always_comb begin
        busy_d = busy_q;
        occ_d  = occ_after_clr + OCC_W'(set_eff);
        if (clr_eff) begin
            busy_d[clr_rd] = 1'b0;
        end
        if (set_eff) begin
            busy_d[set_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            occ_q  <= '0;
        end else begin
            busy_q <= busy_d;
            occ_q  <= occ_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: load-use, scoreboard RAW/WAW/full stalls, redirect flush.
// Latency: all controls combinational from inputs and registered busy; busy/stall_cnt registered.
// Backpressure: a stall holds PC and IF_ID and bubbles ID_EX; ex_redirect overrides any stall.
//
// Ports: clk, rst_n (async, active-low); hif (slave) carries ID/ID_EX/WB status in and
// pc_write, if_id_write, if_id_flush, ctrl_sel, stall_cause, busy, stall_cnt out.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int NUM_REGS        = NUM_REGS_DEF,
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    hazard_control_unit_if.slave  hif
);

    localparam int REG_AW = $clog2(NUM_REGS);

    logic                rs1_hit;
    logic                rs2_hit;
    logic                rd_busy;
    logic                sb_full;
    logic [NUM_REGS-1:0] busy;
    logic                load_use;
    logic                long_wr;
    logic                stall;
    logic                issue;
    logic                set_vld;
    haz_cause_e          cause;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

    hazard_scoreboard #(
        .NUM_REGS        (NUM_REGS),
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .REG_AW          (REG_AW)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_vld    (set_vld),
        .set_rd     (hif.id_rd),
        .clr_vld    (hif.wb_done),
        .clr_rd     (hif.wb_rd),
        .q_rs1      (hif.id_rs1),
        .q_rs1_used (hif.id_rs1_used),
        .q_rs2      (hif.id_rs2),
        .q_rs2_used (hif.id_rs2_used),
        .q_rd       (hif.id_rd),
        .rs1_hit    (rs1_hit),
        .rs2_hit    (rs2_hit),
        .rd_busy    (rd_busy),
        .full       (sb_full),
        .busy       (busy)
    );

    // Stall cause, highest priority first. A load into x0 never hazards,
    // and a long op writing x0 is treated as having no destination.
    always_comb begin
        load_use = hif.id_ex_mem_read && (hif.id_ex_rd != '0)
                   && ((hif.id_rs1_used && (hif.id_rs1 == hif.id_ex_rd))
                    || (hif.id_rs2_used && (hif.id_rs2 == hif.id_ex_rd)));
        long_wr  = hif.id_long_op && (hif.id_rd != '0);

        cause = HAZ_NONE;
        if (hif.id_valid) begin
            if (load_use) begin
                cause = HAZ_LOAD_USE;
            end else if (rs1_hit || rs2_hit) begin
                cause = HAZ_SB_RAW;
            end else if (long_wr && rd_busy) begin
                cause = HAZ_SB_WAW;
            end else if (long_wr && sb_full) begin
                cause = HAZ_SB_FULL;
            end
        end
        stall = (cause != HAZ_NONE);
    end

    // Pipeline controls. The redirect kills the ID instruction, so whatever it
    // was waiting on no longer matters: fetch resumes and nothing is issued.
    always_comb begin
        issue   = hif.id_valid && !stall && !hif.ex_redirect;
        set_vld = issue && long_wr;

        hif.pc_write    = 1'b1;
        hif.if_id_write = 1'b1;
        hif.if_id_flush = 1'b0;
        hif.ctrl_sel    = 1'b1;
        hif.stall_cause = HAZ_NONE;

        if (hif.ex_redirect) begin
            hif.if_id_flush = 1'b1;
            hif.ctrl_sel    = 1'b0;
        end else if (stall) begin
            hif.pc_write    = 1'b0;
            hif.if_id_write = 1'b0;
            hif.ctrl_sel    = 1'b0;
            hif.stall_cause = cause;
        end
    end

    // Performance counter: counts effective stall cycles, sticks at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !hif.ex_redirect
            && !cnt_saturated(64'(stall_cnt_q), CNT_W)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hif.busy      = busy;
    assign hif.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: table of combinational vectors on a frozen
// scoreboard state plus clocked sequences (load-use, long RAW, full/WAW, redirect, reset).
// A second instance with a 4-bit stall counter shares the stimulus to show saturation.
module tb_hazard_control_unit;
    import hazard_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.NUM_REGS(32), .CNT_W(32)) hif ();
    hazard_control_unit_if #(.NUM_REGS(32), .CNT_W(4))  hif4 ();

    assign hif4.id_valid       = hif.id_valid;
    assign hif4.id_rs1         = hif.id_rs1;
    assign hif4.id_rs2         = hif.id_rs2;
    assign hif4.id_rs1_used    = hif.id_rs1_used;
    assign hif4.id_rs2_used    = hif.id_rs2_used;
    assign hif4.id_rd          = hif.id_rd;
    assign hif4.id_long_op     = hif.id_long_op;
    assign hif4.id_ex_mem_read = hif.id_ex_mem_read;
    assign hif4.id_ex_rd       = hif.id_ex_rd;
    assign hif4.wb_done        = hif.wb_done;
    assign hif4.wb_rd          = hif.wb_rd;
    assign hif4.ex_redirect    = hif.ex_redirect;

    hazard_control_unit #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif)
    );

    hazard_control_unit #(.NUM_REGS(32), .MAX_OUTSTANDING(4), .CNT_W(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .hif   (hif4)
    );

    // Expected {pc_write, if_id_write, if_id_flush, ctrl_sel}
    localparam logic [3:0] C_RUN   = 4'b1101;
    localparam logic [3:0] C_STALL = 4'b0000;
    localparam logic [3:0] C_REDIR = 4'b1110;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       lng;
        logic       mr;
        logic [4:0] exrd;
        logic       wb;
        logic [4:0] wbrd;
        logic       redir;
        logic [3:0] ctl;
        haz_cause_e cause;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string name, input logic [3:0] ctl, input haz_cause_e cause);
        check(name,
              {25'd0, hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.ctrl_sel, hif.stall_cause},
              {25'd0, ctl, cause});
    endtask

    task automatic set_idle();
        hif.id_valid       = 1'b0;
        hif.id_rs1         = '0;
        hif.id_rs2         = '0;
        hif.id_rs1_used    = 1'b0;
        hif.id_rs2_used    = 1'b0;
        hif.id_rd          = '0;
        hif.id_long_op     = 1'b0;
        hif.id_ex_mem_read = 1'b0;
        hif.id_ex_rd       = '0;
        hif.wb_done        = 1'b0;
        hif.wb_rd          = '0;
        hif.ex_redirect    = 1'b0;
    endtask

    task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic lng);
        hif.id_valid    = v;
        hif.id_rs1      = rs1;
        hif.id_rs1_used = u1;
        hif.id_rs2      = rs2;
        hif.id_rs2_used = u2;
        hif.id_rd       = rd;
        hif.id_long_op  = lng;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic v,
                                input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] rd, input logic lng,
                                input logic mr, input logic [4:0] exrd,
                                input logic wb, input logic [4:0] wbrd,
                                input logic redir, input logic [3:0] ctl,
                                input haz_cause_e cause);
        vec_t t;
        t.name = name; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.lng = lng; t.mr = mr; t.exrd = exrd; t.wb = wb; t.wbrd = wbrd;
        t.redir = redir; t.ctl = ctl; t.cause = cause;
        return t;
    endfunction

    initial begin
        // Vectors evaluated against scoreboard busy = {x1, x2, x4, x9}, occupancy 4.
        //                name                 v  rs1 u1 rs2 u2 rd  lng mr exrd wb wbrd rd ctl      cause
        vq.push_back(mk("id_invalid",         0, 1,  1, 0,  0, 0,  0,  0, 0,  0, 0,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("raw_rs1",            1, 1,  1, 0,  0, 0,  0,  0, 0,  0, 0,  0, C_STALL, HAZ_SB_RAW));
        vq.push_back(mk("rs2_busy_unused",    1, 5,  1, 2,  0, 0,  0,  0, 0,  0, 0,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("raw_rs2",            1, 0,  0, 9,  1, 0,  0,  0, 0,  0, 0,  0, C_STALL, HAZ_SB_RAW));
        vq.push_back(mk("raw_wb_bypass",      1, 1,  1, 0,  0, 0,  0,  0, 0,  1, 1,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("long_x0_when_full",  1, 0,  0, 0,  0, 0,  1,  0, 0,  0, 0,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("waw",                1, 0,  0, 0,  0, 4,  1,  0, 0,  0, 0,  0, C_STALL, HAZ_SB_WAW));
        vq.push_back(mk("waw_wb_clear",       1, 0,  0, 0,  0, 4,  1,  0, 0,  1, 4,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("full",               1, 0,  0, 0,  0, 12, 1,  0, 0,  0, 0,  0, C_STALL, HAZ_SB_FULL));
        vq.push_back(mk("full_wb_idle_reg",   1, 0,  0, 0,  0, 12, 1,  0, 0,  1, 5,  0, C_STALL, HAZ_SB_FULL));
        vq.push_back(mk("full_wb_frees",      1, 0,  0, 0,  0, 12, 1,  0, 0,  1, 9,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("lu_over_raw",        1, 1,  1, 0,  0, 0,  0,  1, 1,  0, 0,  0, C_STALL, HAZ_LOAD_USE));
        vq.push_back(mk("lu_x0_ignored",      1, 0,  1, 0,  0, 0,  0,  1, 0,  0, 0,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("lu_rs2",             1, 0,  0, 3,  1, 0,  0,  1, 3,  0, 0,  0, C_STALL, HAZ_LOAD_USE));
        vq.push_back(mk("lu_rs2_unused",      1, 0,  0, 3,  0, 0,  0,  1, 3,  0, 0,  0, C_RUN,   HAZ_NONE));
        vq.push_back(mk("raw_over_full",      1, 2,  1, 0,  0, 12, 1,  0, 0,  0, 0,  0, C_STALL, HAZ_SB_RAW));
        vq.push_back(mk("redirect_over_raw",  1, 1,  1, 0,  0, 0,  0,  0, 0,  0, 0,  1, C_REDIR, HAZ_NONE));

        // ---------------- reset ----------------
        rst_n = 1'b0;
        set_idle();
        #3;
        check("rst_busy", hif.busy, 32'h0);
        check("rst_cnt", hif.stall_cnt, 32'd0);
        check_ctl("rst_ctl", C_RUN, HAZ_NONE);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- load-use ----------------
        tick();
        drv(1, 5'd5, 1, 5'd1, 1, 5'd6, 0);
        hif.id_ex_mem_read = 1'b1;
        hif.id_ex_rd       = 5'd5;
        @(negedge clk);
        check_ctl("lu_stall", C_STALL, HAZ_LOAD_USE);
        tick();
        hif.id_ex_mem_read = 1'b0;
        hif.id_ex_rd       = '0;
        @(negedge clk);
        check_ctl("lu_release", C_RUN, HAZ_NONE);
        check("lu_cnt", hif.stall_cnt, 32'd1);

        // ---------------- RAW on long op ----------------
        tick();
        set_idle();
        drv(1, 5'd8, 1, 5'd9, 1, 5'd7, 1);
        @(negedge clk);
        check_ctl("div_issue", C_RUN, HAZ_NONE);
        tick();
        drv(1, 5'd7, 1, 5'd2, 1, 5'd10, 0);
        check("busy7_set", hif.busy, 32'h80);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_ctl("raw_wait", C_STALL, HAZ_SB_RAW);
            tick();
        end
        hif.wb_done = 1'b1;
        hif.wb_rd   = 5'd7;
        @(negedge clk);
        check_ctl("raw_issue_on_wb", C_RUN, HAZ_NONE);
        check("busy7_still_set", hif.busy, 32'h80);
        check("raw_cnt", hif.stall_cnt, 32'd11);
        tick();
        set_idle();
        check("busy7_clear", hif.busy, 32'h0);

        // ---------------- full / WAW ----------------
        for (int r = 1; r <= 4; r++) begin
            drv(1, 5'd0, 0, 5'd0, 0, 5'(r), 1);
            @(negedge clk);
            check_ctl("long_issue", C_RUN, HAZ_NONE);
            tick();
        end
        check("busy_x1_x4", hif.busy, 32'h1E);
        drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1);
        @(negedge clk);
        check_ctl("full_1", C_STALL, HAZ_SB_FULL);
        tick();
        @(negedge clk);
        check_ctl("full_2", C_STALL, HAZ_SB_FULL);
        tick();
        drv(1, 5'd0, 0, 5'd0, 0, 5'd2, 1);
        @(negedge clk);
        check_ctl("waw_x2", C_STALL, HAZ_SB_WAW);
        tick();
        drv(1, 5'd0, 0, 5'd0, 0, 5'd9, 1);
        hif.wb_done = 1'b1;
        hif.wb_rd   = 5'd3;
        @(negedge clk);
        check_ctl("full_release_on_wb", C_RUN, HAZ_NONE);
        tick();
        set_idle();
        check("busy_swap", hif.busy, 32'h216);
        check("full_cnt", hif.stall_cnt, 32'd14);
        check("full_cnt4", {28'd0, hif4.stall_cnt}, 32'd14);

        // ---------------- combinational table ----------------
        foreach (vq[k]) begin
            @(negedge clk);
            drv(vq[k].v, vq[k].rs1, vq[k].u1, vq[k].rs2, vq[k].u2, vq[k].rd, vq[k].lng);
            hif.id_ex_mem_read = vq[k].mr;
            hif.id_ex_rd       = vq[k].exrd;
            hif.wb_done        = vq[k].wb;
            hif.wb_rd          = vq[k].wbrd;
            hif.ex_redirect    = vq[k].redir;
            #2;
            check_ctl(vq[k].name, vq[k].ctl, vq[k].cause);
            set_idle();
        end
        tick();
        check("table_busy_kept", hif.busy, 32'h216);
        check("table_cnt_kept", hif.stall_cnt, 32'd14);

        // ---------------- redirect during RAW stall ----------------
        drv(1, 5'd9, 1, 5'd0, 0, 5'd11, 1);
        hif.ex_redirect = 1'b1;
        @(negedge clk);
        check_ctl("redir_during_raw", C_REDIR, HAZ_NONE);
        tick();
        set_idle();
        check("redir_no_set", hif.busy, 32'h216);
        check("redir_cnt", hif.stall_cnt, 32'd14);

        // ---------------- x0 and unused sources ----------------
        drv(1, 5'd0, 0, 5'd0, 0, 5'd0, 1);
        @(negedge clk);
        check_ctl("long_x0_issue", C_RUN, HAZ_NONE);
        tick();
        set_idle();
        check("long_x0_no_set", hif.busy, 32'h216);
        hif.wb_done = 1'b1;
        hif.wb_rd   = 5'd1;
        tick();
        set_idle();
        drv(1, 5'd0, 0, 5'd0, 0, 5'd7, 1);
        @(negedge clk);
        check_ctl("long_x7_issue", C_RUN, HAZ_NONE);
        tick();
        set_idle();
        check("busy_x7_set", hif.busy, 32'h294);
        drv(1, 5'd0, 0, 5'd7, 0, 5'd12, 0);
        @(negedge clk);
        check_ctl("rs2_x7_unused", C_RUN, HAZ_NONE);
        hif.id_rs2_used = 1'b1;
        #1;
        check_ctl("rs2_x7_used", C_STALL, HAZ_SB_RAW);
        tick();
        set_idle();
        check("cnt4_at_15", {28'd0, hif4.stall_cnt}, 32'd15);

        // ---------------- saturation and reset mid-stall ----------------
        hif.wb_done = 1'b1;
        hif.wb_rd   = 5'd4;
        tick();
        hif.wb_rd   = 5'd9;
        tick();
        set_idle();
        check("busy_0x84", hif.busy, 32'h84);
        drv(1, 5'd7, 1, 5'd0, 0, 5'd13, 0);
        @(negedge clk);
        check_ctl("pre_rst_raw", C_STALL, HAZ_SB_RAW);
        tick();
        @(negedge clk);
        check_ctl("pre_rst_raw_hold", C_STALL, HAZ_SB_RAW);
        tick();
        check("cnt_before_rst", hif.stall_cnt, 32'd17);
        check("cnt4_saturated", {28'd0, hif4.stall_cnt}, 32'd15);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_busy", hif.busy, 32'h0);
        check("rst_mid_cnt", hif.stall_cnt, 32'd0);
        check("rst_mid_cnt4", {28'd0, hif4.stall_cnt}, 32'd0);
        check_ctl("rst_mid_ctl", C_RUN, HAZ_NONE);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", hif.busy, 32'h0);
        check_ctl("post_rst_no_stall", C_RUN, HAZ_NONE);
        set_idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
